ball_tracker: RTL



---
 rtl/ball_tracker_pkg.sv | 21 ++
 rtl/ball_tracker_axis.sv | 29 ++
 rtl/ball_tracker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ball_tracker_pkg.sv
// Shared types and default widths for the ball_tracker pixel-stream object tracker.
package ball_tracker_pkg;

  localparam int unsigned DEF_DW         = 10;
  localparam int unsigned DEF_XW         = 12;
  localparam int unsigned DEF_YW         = 12;
  localparam int unsigned DEF_CW         = 24;
  localparam int unsigned DEF_MIN_PIXELS = 4;

  localparam logic [DEF_XW-1:0] DEF_X_SAT   = {DEF_XW{1'b1}};
  localparam logic [DEF_YW-1:0] DEF_Y_SAT   = {DEF_YW{1'b1}};
  localparam logic [DEF_CW-1:0] DEF_CNT_SAT = {DEF_CW{1'b1}};

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/ball_tracker_axis.sv
// One bounding-box axis: running min/max of qualifying coordinates, reinitialised per frame.
module ball_tracker_axis
  import ball_tracker_pkg::*;
#(
  parameter int unsigned W = DEF_XW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         upd,
  input  logic [W-1:0] val,
  output logic [W-1:0] v_min,
  output logic [W-1:0] v_max
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_min <= '1;
      v_max <= '0;
    end else if (init) begin
      v_min <= '1;
      v_max <= '0;
    end else if (upd) begin
      if (val < v_min) v_min <= val;
      if (val > v_max) v_max <= val;
    end
  end

endmodule

// File: rtl/ball_tracker.sv
// Per-frame threshold tracker: bounding box and count of bright samples, published with valid/ack.
// Optional region of interest: define BALL_TRACKER_ROI_EN.
module ball_tracker
  import ball_tracker_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned XW         = DEF_XW,
  parameter int unsigned YW         = DEF_YW,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned MIN_PIXELS = DEF_MIN_PIXELS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pix_d,
  input  logic          fval,
  input  logic          lval,
  input  logic [DW-1:0] threshold,
`ifdef BALL_TRACKER_ROI_EN
  input  logic [XW-1:0] roi_x0,
  input  logic [XW-1:0] roi_x1,
  input  logic [YW-1:0] roi_y0,
  input  logic [YW-1:0] roi_y1,
`endif
  input  logic          result_ack,
  output logic          result_valid,
  output logic          found,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] pix_count,
  output logic          overrun,
  output logic          frame_active
);

  localparam logic [XW-1:0] X_SAT   = {XW{1'b1}};
  localparam logic [YW-1:0] Y_SAT   = {YW{1'b1}};
  localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

  state_t        state;
  logic [DW-1:0] pix_q;
  logic          fval_q, lval_q, fval_d, line_d;
  logic [DW-1:0] thr_l;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] cnt;
  logic [XW-1:0] ax_min, ax_max;
  logic [YW-1:0] ay_min, ay_max;
  logic          in_line, in_roi, frame_start, qual, has_found;

`ifdef BALL_TRACKER_ROI_EN
  logic [XW-1:0] rx0_l, rx1_l;
  logic [YW-1:0] ry0_l, ry1_l;
  assign in_roi = (x >= rx0_l) && (x <= rx1_l) && (y >= ry0_l) && (y <= ry1_l);
`else
  assign in_roi = 1'b1;
`endif

  assign in_line     = fval_q && lval_q;
  assign frame_start = (state == ARMED) && fval_q && !fval_d;
  assign qual        = (state == ACTIVE) && in_line && (pix_q >= thr_l) && in_roi;
  assign has_found   = (cnt >= MIN_CNT);

  // Input stage; fval_d resets high so SYNC only arms after a real low sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q  <= '0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      fval_d <= 1'b1;
      line_d <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      fval_q <= fval;
      lval_q <= lval;
      fval_d <= fval_q;
      line_d <= in_line;
    end
  end

  ball_tracker_axis #(.W(XW)) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .init  (frame_start),
    .upd   (qual),
    .val   (x),
    .v_min (ax_min),
    .v_max (ax_max)
  );

  ball_tracker_axis #(.W(YW)) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .init  (frame_start),
    .upd   (qual),
    .val   (y),
    .v_min (ay_min),
    .v_max (ay_max)
  );

  // Frame FSM, position counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC;
      x            <= '0;
      y            <= '0;
      cnt          <= '0;
      thr_l        <= '0;
      result_valid <= 1'b0;
      found        <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      pix_count    <= '0;
      overrun      <= 1'b0;
      frame_active <= 1'b0;
`ifdef BALL_TRACKER_ROI_EN
      rx0_l        <= '0;
      rx1_l        <= '0;
      ry0_l        <= '0;
      ry1_l        <= '0;
`endif
    end else begin
      if (result_ack && result_valid) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end
      case (state)
        SYNC: begin
          if (!fval_q && !fval_d) state <= ARMED;
        end
        ARMED: begin
          if (frame_start) begin
            state        <= ACTIVE;
            frame_active <= 1'b1;
            x            <= '0;
            y            <= '0;
            cnt          <= '0;
            thr_l        <= threshold;
`ifdef BALL_TRACKER_ROI_EN
            rx0_l        <= roi_x0;
            rx1_l        <= roi_x1;
            ry0_l        <= roi_y0;
            ry1_l        <= roi_y1;
`endif
          end
        end
        ACTIVE: begin
          if (!fval_q) begin
            state        <= PUBLISH;
            frame_active <= 1'b0;
          end else if (lval_q) begin
            if (x != X_SAT) x <= x + XW'(1);
            if (qual && (cnt != CNT_SAT)) cnt <= cnt + CW'(1);
          end else if (line_d) begin
            x <= '0;
            if (y != Y_SAT) y <= y + YW'(1);
          end
        end
        PUBLISH: begin
          state        <= ARMED;
          result_valid <= 1'b1;
          found        <= has_found;
          x_min        <= has_found ? ax_min : '0;
          x_max        <= has_found ? ax_max : '0;
          y_min        <= has_found ? ay_min : '0;
          y_max        <= has_found ? ay_max : '0;
          pix_count    <= cnt;
          if (result_valid && !result_ack) overrun <= 1'b1;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
